control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 122 ++++++++++++
 rtl/cu_step_decode.sv | 141 ++++++++++++++
 rtl/control_unit.sv | 123 ++++++++++++
 tb/tb_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, state encoding,
// the control-word layout and opcode classification helpers.
package control_unit_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = OP_ADD;

    localparam logic [3:0] ST_T0   = 4'd0;
    localparam logic [3:0] ST_T1   = 4'd1;
    localparam logic [3:0] ST_T2   = 4'd2;
    localparam logic [3:0] ST_T3   = 4'd3;
    localparam logic [3:0] ST_T4   = 4'd4;
    localparam logic [3:0] ST_T5   = 4'd5;
    localparam logic [3:0] ST_T6   = 4'd6;
    localparam logic [3:0] ST_T7   = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    typedef enum logic [3:0] {
        CLS_RR, CLS_IMM, CLS_UNARY, CLS_MULDIV, CLS_LD, CLS_LDI, CLS_ST,
        CLS_BR, CLS_JR, CLS_MFHI, CLS_MFLO, CLS_IN, CLS_OUT, CLS_NOP, CLS_HALT
    } op_class_t;

    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       rin;
        logic       rout;
        logic       ba_out;
        logic       hi_in;
        logic       hi_out;
        logic       lo_in;
        logic       lo_out;
        logic       z_in;
        logic       z_high_out;
        logic       z_low_out;
        logic       y_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       mar_in;
        logic       pc_in;
        logic       pc_out;
        logic       ir_in;
        logic       inc_pc;
        logic       c_out;
        logic       read;
        logic       ram_write;
        logic       con_in;
        logic       in_port_out;
        logic       out_port_in;
        logic [4:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.alu_op = ALU_ADD;
        return c;
    endfunction

    // Unassigned opcodes (including 10100) execute as nop.
    function automatic op_class_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:     return CLS_RR;
            OP_ADDI, OP_ANDI, OP_ORI:    return CLS_IMM;
            OP_NEG, OP_NOT:              return CLS_UNARY;
            OP_MUL, OP_DIV:              return CLS_MULDIV;
            OP_LD:                       return CLS_LD;
            OP_LDI:                      return CLS_LDI;
            OP_ST:                       return CLS_ST;
            OP_BR:                       return CLS_BR;
            OP_JR:                       return CLS_JR;
            OP_MFHI:                     return CLS_MFHI;
            OP_MFLO:                     return CLS_MFLO;
            OP_IN:                       return CLS_IN;
            OP_OUT:                      return CLS_OUT;
            OP_HALT:                     return CLS_HALT;
            default:                     return CLS_NOP;
        endcase
    endfunction

    function automatic logic [3:0] last_step(input op_class_t cls);
        case (cls)
            CLS_RR, CLS_IMM, CLS_LDI:            return ST_T5;
            CLS_UNARY:                           return ST_T4;
            CLS_MULDIV, CLS_BR:                  return ST_T6;
            CLS_LD, CLS_ST:                      return ST_T7;
            CLS_JR, CLS_MFHI, CLS_MFLO,
            CLS_IN, CLS_OUT:                     return ST_T3;
            default:                             return ST_T2;
        endcase
    endfunction

endpackage

// File: rtl/cu_step_decode.sv
// Pure combinational map from {state, opcode, con} to the full control word.
// con only reaches pc_in in the branch writeback step.
module cu_step_decode
    import control_unit_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [4:0] i_opcode,
    input  logic       i_con,
    output ctrl_t      o_ctrl
);

    op_class_t w_class;
    ctrl_t     w_ctrl;

    assign w_class = op_class(i_opcode);
    assign o_ctrl  = w_ctrl;

    always_comb begin
        w_ctrl = ctrl_idle();
        case (i_state)
            ST_T0: begin
                w_ctrl.pc_out = 1'b1; w_ctrl.mar_in = 1'b1;
                w_ctrl.inc_pc = 1'b1; w_ctrl.z_in   = 1'b1;
            end
            ST_T1: begin
                w_ctrl.z_low_out = 1'b1; w_ctrl.pc_in  = 1'b1;
                w_ctrl.read      = 1'b1; w_ctrl.mdr_in = 1'b1;
            end
            ST_T2: begin
                w_ctrl.mdr_out = 1'b1; w_ctrl.ir_in = 1'b1;
            end
            ST_T3: begin
                case (w_class)
                    CLS_RR, CLS_IMM: begin
                        w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
                        w_ctrl.alu_op = i_opcode;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.y_in = 1'b1;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        w_ctrl.grb = 1'b1; w_ctrl.ba_out = 1'b1; w_ctrl.y_in = 1'b1;
                    end
                    CLS_BR: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.con_in = 1'b1;
                    end
                    CLS_JR: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.pc_in = 1'b1;
                    end
                    CLS_MFHI: begin
                        w_ctrl.hi_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_MFLO: begin
                        w_ctrl.lo_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_IN: begin
                        w_ctrl.in_port_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_OUT: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.out_port_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_class)
                    CLS_RR: begin
                        w_ctrl.grc = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
                        w_ctrl.alu_op = i_opcode;
                    end
                    CLS_IMM: begin
                        w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1;
                        w_ctrl.alu_op = i_opcode;
                    end
                    CLS_UNARY: begin
                        w_ctrl.z_low_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.z_in = 1'b1;
                        w_ctrl.alu_op = i_opcode;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1;
                    end
                    CLS_BR: begin
                        w_ctrl.pc_out = 1'b1; w_ctrl.y_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_class)
                    CLS_RR, CLS_IMM, CLS_LDI: begin
                        w_ctrl.z_low_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.z_low_out = 1'b1; w_ctrl.lo_in = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        w_ctrl.z_low_out = 1'b1; w_ctrl.mar_in = 1'b1;
                    end
                    CLS_BR: begin
                        w_ctrl.c_out = 1'b1; w_ctrl.z_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (w_class)
                    CLS_MULDIV: begin
                        w_ctrl.z_high_out = 1'b1; w_ctrl.hi_in = 1'b1;
                    end
                    CLS_LD: begin
                        w_ctrl.read = 1'b1; w_ctrl.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.mdr_in = 1'b1;
                    end
                    CLS_BR: begin
                        w_ctrl.z_low_out = 1'b1; w_ctrl.pc_in = i_con;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (w_class)
                    CLS_LD: begin
                        w_ctrl.mdr_out = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1;
                    end
                    CLS_ST:  w_ctrl.ram_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: state register and sequencing only; the control
// word for each step comes from cu_step_decode.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con,
    input  logic        stop,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Yin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        PCout,
    output logic        IRin,
    output logic        IncPC,
    output logic        Cout,
    output logic        read,
    output logic        RAMwrite,
    output logic        CONin,
    output logic        InPortout,
    output logic        OutPortin,
    output logic [4:0]  alu_op,
    output logic        run
);
    import control_unit_pkg::*;

    logic [3:0] r_state;
    logic [3:0] w_state_next;
    op_class_t  w_class;
    ctrl_t      w_ctrl;
    ctrl_t      w_out;
    logic       w_unused_ir;

    assign w_class     = op_class(ir[31:27]);
    assign w_unused_ir = ^ir[26:0];

    // The opcode is taken from ir while in T2; it must already hold the word being fetched.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_T0: w_state_next = ST_T1;
            ST_T1: w_state_next = ST_T2;
            ST_T2: begin
                if (stop || (w_class == CLS_HALT))
                    w_state_next = ST_HALT;
                else if (w_class == CLS_NOP)
                    w_state_next = ST_T0;
                else
                    w_state_next = ST_T3;
            end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (r_state == last_step(w_class))
                    w_state_next = ST_T0;
                else
                    w_state_next = r_state + 4'd1;
            end
            ST_HALT: w_state_next = ST_HALT;
            default: w_state_next = ST_T0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear)
            r_state <= ST_T0;
        else
            r_state <= w_state_next;
    end

    cu_step_decode u_step_decode (
        .i_state  (r_state),
        .i_opcode (ir[31:27]),
        .i_con    (con),
        .o_ctrl   (w_ctrl)
    );

    // Holding clear low masks the whole control word, so nothing fires during reset.
    assign w_out = clear ? w_ctrl : ctrl_idle();
    assign run   = clear && (r_state != ST_HALT);

    assign Gra       = w_out.gra;
    assign Grb       = w_out.grb;
    assign Grc       = w_out.grc;
    assign Rin       = w_out.rin;
    assign Rout      = w_out.rout;
    assign BAout     = w_out.ba_out;
    assign HIin      = w_out.hi_in;
    assign HIout     = w_out.hi_out;
    assign LOin      = w_out.lo_in;
    assign LOout     = w_out.lo_out;
    assign Zin       = w_out.z_in;
    assign Zhighout  = w_out.z_high_out;
    assign Zlowout   = w_out.z_low_out;
    assign Yin       = w_out.y_in;
    assign MDRin     = w_out.mdr_in;
    assign MDRout    = w_out.mdr_out;
    assign MARin     = w_out.mar_in;
    assign PCin      = w_out.pc_in;
    assign PCout     = w_out.pc_out;
    assign IRin      = w_out.ir_in;
    assign IncPC     = w_out.inc_pc;
    assign Cout      = w_out.c_out;
    assign read      = w_out.read;
    assign RAMwrite  = w_out.ram_write;
    assign CONin     = w_out.con_in;
    assign InPortout = w_out.in_port_out;
    assign OutPortin = w_out.out_port_in;
    assign alu_op    = w_out.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized instruction sequences checked cycle by cycle
// against a micro-program table built from the instruction descriptions.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear, con, stop;
    logic [31:0] ir;
    logic Gra, Grb, Grc, Rin, Rout, BAout, HIin, HIout, LOin, LOout, Zin;
    logic Zhighout, Zlowout, Yin, MDRin, MDRout, MARin, PCin, PCout, IRin;
    logic IncPC, Cout, read, RAMwrite, CONin, InPortout, OutPortin;
    logic [4:0] alu_op;
    logic       run;

    always #5 clock = ~clock;

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .con(con), .stop(stop),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .Zin(Zin),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .Yin(Yin), .MDRin(MDRin),
        .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .PCout(PCout), .IRin(IRin),
        .IncPC(IncPC), .Cout(Cout), .read(read), .RAMwrite(RAMwrite),
        .CONin(CONin), .InPortout(InPortout), .OutPortin(OutPortin),
        .alu_op(alu_op), .run(run)
    );

    logic [26:0] obs_sig;
    assign obs_sig = {Gra, Grb, Grc, Rin, Rout, BAout, HIin, HIout, LOin, LOout,
                      Zin, Zhighout, Zlowout, Yin, MDRin, MDRout, MARin, PCin,
                      PCout, IRin, IncPC, Cout, read, RAMwrite, CONin,
                      InPortout, OutPortin};

    localparam logic [26:0] GRA = 27'd1 << 26, GRB = 27'd1 << 25, GRC = 27'd1 << 24;
    localparam logic [26:0] RIN = 27'd1 << 23, ROUT = 27'd1 << 22, BAOUT = 27'd1 << 21;
    localparam logic [26:0] HIIN = 27'd1 << 20, HIOUT = 27'd1 << 19;
    localparam logic [26:0] LOIN = 27'd1 << 18, LOOUT = 27'd1 << 17;
    localparam logic [26:0] ZIN = 27'd1 << 16, ZHI = 27'd1 << 15, ZLO = 27'd1 << 14;
    localparam logic [26:0] YIN = 27'd1 << 13, MDRIN = 27'd1 << 12, MDROUT = 27'd1 << 11;
    localparam logic [26:0] MARIN = 27'd1 << 10, PCIN = 27'd1 << 9, PCOUT = 27'd1 << 8;
    localparam logic [26:0] IRIN = 27'd1 << 7, INCPC = 27'd1 << 6, COUT = 27'd1 << 5;
    localparam logic [26:0] READ = 27'd1 << 4, RAMW = 27'd1 << 3, CONIN = 27'd1 << 2;
    localparam logic [26:0] INP = 27'd1 << 1, OUTP = 27'd1 << 0;
    localparam logic [4:0]  ADD = 5'b00011;

    int tests = 0;
    int fails = 0;

    // Micro-program for steps T3 onward of the current instruction.
    logic [26:0] prog_q[$];
    int          alu_step;
    bit          halts;

    task automatic build(input logic [4:0] op);
        prog_q.delete();
        alu_step = -1;
        halts    = 1'b0;
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                prog_q = '{GRB|ROUT|YIN, GRC|ROUT|ZIN, ZLO|GRA|RIN};
                alu_step = 4;
            end
            5'd12, 5'd13, 5'd14: begin
                prog_q = '{GRB|ROUT|YIN, COUT|ZIN, ZLO|GRA|RIN};
                alu_step = 4;
            end
            5'd17, 5'd18: begin
                prog_q = '{GRB|ROUT|ZIN, ZLO|GRA|RIN};
                alu_step = 3;
            end
            5'd15, 5'd16: begin
                prog_q = '{GRA|ROUT|YIN, GRB|ROUT|ZIN, ZLO|LOIN, ZHI|HIIN};
                alu_step = 4;
            end
            5'd0:  prog_q = '{GRB|BAOUT|YIN, COUT|ZIN, ZLO|MARIN, READ|MDRIN, MDROUT|GRA|RIN};
            5'd1:  prog_q = '{GRB|BAOUT|YIN, COUT|ZIN, ZLO|GRA|RIN};
            5'd2:  prog_q = '{GRB|BAOUT|YIN, COUT|ZIN, ZLO|MARIN, GRA|ROUT|MDRIN, RAMW};
            5'd19: prog_q = '{GRA|ROUT|CONIN, PCOUT|YIN, COUT|ZIN, ZLO};
            5'd21: prog_q = '{GRA|ROUT|PCIN};
            5'd22: prog_q = '{INP|GRA|RIN};
            5'd23: prog_q = '{GRA|ROUT|OUTP};
            5'd24: prog_q = '{LOOUT|GRA|RIN};
            5'd25: prog_q = '{HIOUT|GRA|RIN};
            5'd27: halts = 1'b1;
            default: ;
        endcase
    endtask

    task automatic check_cycle(input logic [26:0] es, input logic [4:0] ea,
                               input logic er, input string tag);
        @(negedge clock);
        tests++;
        assert (obs_sig === es) else begin
            fails++;
            $error("FAIL %s signals: got %07h expected %07h", tag, obs_sig, es);
        end
        tests++;
        assert (alu_op === ea) else begin
            fails++;
            $error("FAIL %s alu_op: got %05b expected %05b", tag, alu_op, ea);
        end
        tests++;
        assert (run === er) else begin
            fails++;
            $error("FAIL %s run: got %0b expected %0b", tag, run, er);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        check_cycle('0, ADD, 1'b0, "reset0");
        check_cycle('0, ADD, 1'b0, "reset1");
        clear = 1'b1;
    endtask

    // con_mode < 0 randomizes con every cycle; abort_state drops clear in that step.
    task automatic run_instr(input logic [31:0] irv, input bit stop_t2,
                             input int con_mode, input int abort_state);
        logic [4:0]  op;
        logic [26:0] es;
        logic [4:0]  ea;
        int          st;
        op = irv[31:27];
        ir = irv;
        build(op);
        con = 1'($urandom); stop = 1'($urandom);
        check_cycle(PCOUT|MARIN|INCPC|ZIN, ADD, 1'b1, $sformatf("op%02h T0", op));
        con = 1'($urandom); stop = 1'($urandom);
        check_cycle(ZLO|PCIN|READ|MDRIN, ADD, 1'b1, $sformatf("op%02h T1", op));
        con = 1'($urandom); stop = stop_t2;
        check_cycle(MDROUT|IRIN, ADD, 1'b1, $sformatf("op%02h T2", op));
        if (stop_t2 || halts) begin
            for (int i = 0; i < 20; i++) begin
                con = 1'($urandom); stop = 1'($urandom);
                check_cycle('0, ADD, 1'b0, $sformatf("op%02h halt%0d", op, i));
            end
            do_reset();
            return;
        end
        for (int k = 0; k < prog_q.size(); k++) begin
            st   = k + 3;
            con  = (con_mode < 0) ? 1'($urandom) : con_mode[0];
            stop = 1'($urandom);
            if (st == abort_state) begin
                clear = 1'b0;
                check_cycle('0, ADD, 1'b0, $sformatf("op%02h abort T%0d", op, st));
                check_cycle('0, ADD, 1'b0, $sformatf("op%02h abort hold", op));
                clear = 1'b1;
                return;
            end
            es = prog_q[k];
            if (op == 5'd19 && st == 6 && con) es = es | PCIN;
            ea = (st == alu_step) ? op : ADD;
            check_cycle(es, ea, 1'b1, $sformatf("op%02h T%0d", op, st));
        end
    endtask

    logic [4:0] r_op;
    bit         r_stop;
    int         r_abort;

    initial begin
        clear = 1'b0; con = 1'b0; stop = 1'b0; ir = '0;
        @(posedge clock);
        #1;
        do_reset();
        run_instr(32'h1889_0000, 1'b0, -1, -1);                    // add
        run_instr({5'b00000, 27'h0123456}, 1'b0, -1, -1);          // ld
        run_instr({5'b10011, 27'h0abcdef}, 1'b0, 0, -1);           // br, con=0
        run_instr({5'b10011, 27'h0abcdef}, 1'b0, 1, -1);           // br, con=1
        run_instr({5'b10000, 27'h1234567}, 1'b0, -1, -1);          // mul
        run_instr({5'b01111, 27'h7654321}, 1'b0, -1, -1);          // div
        run_instr({5'b00010, 27'h0555555}, 1'b0, -1, 6);           // st, cleared in T6
        run_instr({5'b00010, 27'h0555555}, 1'b0, -1, -1);          // st complete
        run_instr({5'b11011, 27'h0}, 1'b0, -1, -1);                // halt
        run_instr(32'h1889_0000, 1'b1, -1, -1);                    // add with stop
        run_instr({5'b11111, 27'h0}, 1'b0, -1, -1);                // undefined
        run_instr({5'b11010, 27'h0}, 1'b0, -1, -1);                // nop
        for (int n = 0; n < 120; n++) begin
            r_op = 5'($urandom_range(0, 31));
            if (r_op == 5'b10100) r_op = 5'b11010;
            r_stop  = ($urandom_range(0, 15) == 0);
            r_abort = ($urandom_range(0, 15) == 0) ? int'($urandom_range(3, 7)) : -1;
            run_instr({r_op, 27'($urandom)}, r_stop, -1, r_abort);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
